hazard_unit: RTL and testbench

Central stall/forward controller for the five-stage MIPS pipeline, directly downstream of the D-stage controller. It consumes the decoder's register addresses, use flags and Tuse/Tnew codes, and keeps its own shadow pipeline of destination/Tnew state for the E, M and W stages. From that state it produces the D-stage stall and the forwarding-mux selects for the D, E and M stages. The datapath muxes and pipeline registers live elsewhere; this block owns only control state.

---
 rtl/hazard_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: stall/forward controller for the five-stage MIPS pipeline.
//
// Keeps a shadow copy of destination/Tnew state for the E, M and W stages.
// From that state and the D-stage decode it produces the D-stage stall and
// the forwarding-mux selects for the D, E and M stages. Only control state
// lives here; the datapath muxes and pipeline registers are elsewhere.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   D_A1, D_A2            rs/rt addresses of the instruction in D
//   D_A1use, D_A2use      D instruction reads rs / rt
//   D_rs_Tuse, D_rt_Tuse  cycles until rs/rt are consumed (5 = never)
//   D_Tnew                cycles until the result exists, counted from D
//   D_Reg_Write, D_WA     D instruction writes the GRF, and its destination
//   Stall                 freeze PC and F/D, bubble into D/E
//   Fwd_D_rs, Fwd_D_rt    D source: 0 GRF, 1 E, 2 M, 3 W
//   Fwd_E_rs, Fwd_E_rt    E source: 0 pipe register, 2 M, 3 W
//   Fwd_M_rt              M store data: 0 pipe register, 1 W
//   Stall_Cnt             saturating stall-cycle counter (HAZARD_PERF_EN only)
//
// Optional feature macro: HAZARD_PERF_EN adds the Stall_Cnt port and counter.
module hazard_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    input  logic        D_A1use,
    input  logic        D_A2use,
    input  logic [3:0]  D_rs_Tuse,
    input  logic [3:0]  D_rt_Tuse,
    input  logic [3:0]  D_Tnew,
    input  logic        D_Reg_Write,
    input  logic [4:0]  D_WA,
    output logic        Stall,
    output logic [1:0]  Fwd_D_rs,
    output logic [1:0]  Fwd_D_rt,
    output logic [1:0]  Fwd_E_rs,
    output logic [1:0]  Fwd_E_rt,
    output logic        Fwd_M_rt
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] Stall_Cnt
`endif
);

    // Shadow state per stage
    logic [4:0] e_a1_q, e_a2_q, e_wa_q;
    logic [3:0] e_tnew_q;
    logic       e_wr_q;
    logic [4:0] m_a2_q, m_wa_q;
    logic [3:0] m_tnew_q;
    logic       m_wr_q;
    logic [4:0] w_wa_q;
    logic       w_wr_q;

    logic [4:0] e_a1_d, e_a2_d, e_wa_d;
    logic [3:0] e_tnew_d;
    logic       e_wr_d;

    // A stage only matches a real write to a non-zero register.
    function automatic logic hit(input logic wr, input logic [4:0] wa, input logic [4:0] r);
        return wr && (wa == r) && (r != 5'd0);
    endfunction

    function automatic logic [3:0] dec_sat(input logic [3:0] t);
        return (t == 4'd0) ? 4'd0 : t - 4'd1;
    endfunction

    function automatic logic need_stall(input logic [4:0] r, input logic use_r,
                                        input logic [3:0] tuse);
        return use_r && ((hit(e_wr_q, e_wa_q, r) && (e_tnew_q > tuse)) ||
                         (hit(m_wr_q, m_wa_q, r) && (m_tnew_q > tuse)));
    endfunction

    // D-stage source: youngest producer whose value is already computed.
    function automatic logic [1:0] fwd_d(input logic [4:0] r);
        if (hit(e_wr_q, e_wa_q, r) && (e_tnew_q == 4'd0)) return 2'd1;
        if (hit(m_wr_q, m_wa_q, r) && (m_tnew_q == 4'd0)) return 2'd2;
        if (hit(w_wr_q, w_wa_q, r))                       return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (hit(m_wr_q, m_wa_q, r) && (m_tnew_q == 4'd0)) return 2'd2;
        if (hit(w_wr_q, w_wa_q, r))                       return 2'd3;
        return 2'd0;
    endfunction

    always_comb begin
        Stall    = need_stall(D_A1, D_A1use, D_rs_Tuse) ||
                   need_stall(D_A2, D_A2use, D_rt_Tuse);
        Fwd_D_rs = fwd_d(D_A1);
        Fwd_D_rt = fwd_d(D_A2);
        Fwd_E_rs = fwd_e(e_a1_q);
        Fwd_E_rt = fwd_e(e_a2_q);
        Fwd_M_rt = hit(w_wr_q, w_wa_q, m_a2_q);
    end

    // E loads the D instruction, or a bubble while stalled.
    always_comb begin
        e_a1_d   = D_A1;
        e_a2_d   = D_A2;
        e_wa_d   = D_WA;
        e_tnew_d = dec_sat(D_Tnew);
        e_wr_d   = D_Reg_Write;
        if (Stall) begin
            e_a1_d   = 5'd0;
            e_a2_d   = 5'd0;
            e_wa_d   = 5'd0;
            e_tnew_d = 4'd0;
            e_wr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a1_q   <= 5'd0;
            e_a2_q   <= 5'd0;
            e_wa_q   <= 5'd0;
            e_tnew_q <= 4'd0;
            e_wr_q   <= 1'b0;
            m_a2_q   <= 5'd0;
            m_wa_q   <= 5'd0;
            m_tnew_q <= 4'd0;
            m_wr_q   <= 1'b0;
            w_wa_q   <= 5'd0;
            w_wr_q   <= 1'b0;
        end else begin
            e_a1_q   <= e_a1_d;
            e_a2_q   <= e_a2_d;
            e_wa_q   <= e_wa_d;
            e_tnew_q <= e_tnew_d;
            e_wr_q   <= e_wr_d;
            m_a2_q   <= e_a2_q;
            m_wa_q   <= e_wa_q;
            m_tnew_q <= dec_sat(e_tnew_q);
            m_wr_q   <= e_wr_q;
            w_wa_q   <= m_wa_q;
            w_wr_q   <= m_wr_q;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Stall_Cnt <= 32'd0;
        end else if (Stall && (Stall_Cnt != 32'hFFFF_FFFF)) begin
            Stall_Cnt <= Stall_Cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_A1, D_A2, D_WA;
    logic       D_A1use, D_A2use, D_Reg_Write;
    logic [3:0] D_rs_Tuse, D_rt_Tuse, D_Tnew;
    logic       Stall;
    logic [1:0] Fwd_D_rs, Fwd_D_rt, Fwd_E_rs, Fwd_E_rt;
    logic       Fwd_M_rt;
`ifdef HAZARD_PERF_EN
    logic [31:0] Stall_Cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk        (clk),
        .reset      (reset),
        .D_A1       (D_A1),
        .D_A2       (D_A2),
        .D_A1use    (D_A1use),
        .D_A2use    (D_A2use),
        .D_rs_Tuse  (D_rs_Tuse),
        .D_rt_Tuse  (D_rt_Tuse),
        .D_Tnew     (D_Tnew),
        .D_Reg_Write(D_Reg_Write),
        .D_WA       (D_WA),
        .Stall      (Stall),
        .Fwd_D_rs   (Fwd_D_rs),
        .Fwd_D_rt   (Fwd_D_rt),
        .Fwd_E_rs   (Fwd_E_rs),
        .Fwd_E_rt   (Fwd_E_rt),
        .Fwd_M_rt   (Fwd_M_rt)
`ifdef HAZARD_PERF_EN
        ,
        .Stall_Cnt  (Stall_Cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Model: in-flight instructions indexed by age ----------------
    // pipe[k] is the instruction that left D k cycles ago (1=E, 2=M, 3=W).
    // Its remaining Tnew is the issue-time Tnew minus its age, floored at 0.
    typedef struct packed {
        logic       wr;
        logic [4:0] wa;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [3:0] tnew;
    } instr_t;

    instr_t      pipe [1:3];
    logic [31:0] m_cnt;

    function automatic int left_tnew(input int k);
        return (int'(pipe[k].tnew) > k) ? int'(pipe[k].tnew) - k : 0;
    endfunction

    function automatic bit holds(input int k, input logic [4:0] r);
        return pipe[k].wr && (pipe[k].wa == r) && (r != 5'd0);
    endfunction

    function automatic bit waits(input logic [4:0] r, input logic u, input logic [3:0] tuse);
        bit s = 1'b0;
        for (int k = 1; k <= 2; k++)
            if (u && holds(k, r) && (left_tnew(k) > int'(tuse))) s = 1'b1;
        return s;
    endfunction

    function automatic bit model_stall();
        return waits(D_A1, D_A1use, D_rs_Tuse) || waits(D_A2, D_A2use, D_rt_Tuse);
    endfunction

    // Youngest stage at or after 'first' holding a finished value of r; W always counts.
    function automatic int source(input logic [4:0] r, input int first);
        for (int k = first; k <= 3; k++)
            if (holds(k, r) && ((k == 3) || (left_tnew(k) == 0))) return k;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= 3; k++) pipe[k] <= '0;
            m_cnt <= 32'd0;
        end else begin
            if (model_stall()) begin
                pipe[1] <= '0;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
            end else begin
                pipe[1] <= '{wr: D_Reg_Write, wa: D_WA, a1: D_A1, a2: D_A2, tnew: D_Tnew};
            end
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_stall", {31'd0, Stall}, {31'd0, model_stall()});
            if (!model_stall()) begin
                check("model_fwd_d_rs", {30'd0, Fwd_D_rs}, 32'(source(D_A1, 1)));
                check("model_fwd_d_rt", {30'd0, Fwd_D_rt}, 32'(source(D_A2, 1)));
                check("model_fwd_e_rs", {30'd0, Fwd_E_rs}, 32'(source(pipe[1].a1, 2)));
                check("model_fwd_e_rt", {30'd0, Fwd_E_rt}, 32'(source(pipe[1].a2, 2)));
                check("model_fwd_m_rt", {31'd0, Fwd_M_rt},
                      (source(pipe[2].a2, 3) == 3) ? 32'd1 : 32'd0);
            end
`ifdef HAZARD_PERF_EN
            check("model_stall_cnt", Stall_Cnt, m_cnt);
`endif
        end
    end

    // ---------------- Directed stimulus ----------------
    task automatic drive(input logic [4:0] a1, input logic u1, input logic [3:0] t1,
                         input logic [4:0] a2, input logic u2, input logic [3:0] t2,
                         input logic [3:0] tn, input logic wr, input logic [4:0] wa);
        D_A1 = a1; D_A1use = u1; D_rs_Tuse = t1;
        D_A2 = a2; D_A2use = u2; D_rt_Tuse = t2;
        D_Tnew = tn; D_Reg_Write = wr; D_WA = wa;
    endtask

    task automatic nop();
        drive(5'd0, 1'b0, 4'd5, 5'd0, 1'b0, 4'd5, 4'd0, 1'b0, 5'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_stall"}, {31'd0, Stall}, 32'd0);
        check({tag, "_fwd"}, {23'd0, Fwd_D_rs, Fwd_D_rt, Fwd_E_rs, Fwd_E_rt, Fwd_M_rt}, 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        nop();
        cyc();
        cyc();
        reset = 1'b1;
        cmp_en = 1'b1;
        #2;
        all_zero("reset_state");

        // lw $8 then add $10,$8,$9: one stall, then E forwards rs from W
        cyc(); drive(5'd29, 1'b1, 4'd1, 5'd0, 1'b0, 4'd5, 4'd3, 1'b1, 5'd8);
        #2; check("lw_first_no_stall", {31'd0, Stall}, 32'd0);
        cyc(); drive(5'd8, 1'b1, 4'd1, 5'd9, 1'b1, 4'd1, 4'd2, 1'b1, 5'd10);
        #2; check("lw_add_stall", {31'd0, Stall}, 32'd1);
        cyc();
        #2; check("lw_add_stall_ends", {31'd0, Stall}, 32'd0);
        cyc(); nop();
        #2; check("lw_add_fwd_e_rs_w", {30'd0, Fwd_E_rs}, 32'd3);

        // add $9 then beq $9,$9: one stall, then D forwards both from M
        cyc(); drive(5'd1, 1'b1, 4'd1, 5'd2, 1'b1, 4'd1, 4'd2, 1'b1, 5'd9);
        cyc(); drive(5'd9, 1'b1, 4'd0, 5'd9, 1'b1, 4'd0, 4'd0, 1'b0, 5'd0);
        #2; check("add_beq_stall", {31'd0, Stall}, 32'd1);
        cyc();
        #2; check("add_beq_stall_ends", {31'd0, Stall}, 32'd0);
        check("add_beq_fwd_d_rs", {30'd0, Fwd_D_rs}, 32'd2);
        check("add_beq_fwd_d_rt", {30'd0, Fwd_D_rt}, 32'd2);

        // jal then jr $31: no stall, D forwards from E
        cyc(); drive(5'd0, 1'b0, 4'd5, 5'd0, 1'b0, 4'd5, 4'd1, 1'b1, 5'd31);
        cyc(); drive(5'd31, 1'b1, 4'd0, 5'd0, 1'b0, 4'd5, 4'd0, 1'b0, 5'd0);
        #2; check("jal_jr_no_stall", {31'd0, Stall}, 32'd0);
        check("jal_jr_fwd_d_rs", {30'd0, Fwd_D_rs}, 32'd1);

        // lw $5 then sw rt=$5 (Tuse 2): no stall, M store data from W
        cyc(); drive(5'd29, 1'b1, 4'd1, 5'd0, 1'b0, 4'd5, 4'd3, 1'b1, 5'd5);
        cyc(); drive(5'd29, 1'b1, 4'd1, 5'd5, 1'b1, 4'd2, 4'd0, 1'b0, 5'd0);
        #2; check("lw_sw_no_stall", {31'd0, Stall}, 32'd0);
        cyc(); nop();
        cyc();
        #2; check("lw_sw_fwd_m_rt", {31'd0, Fwd_M_rt}, 32'd1);

        // write to $0 then reader of $0: nothing happens
        cyc(); drive(5'd0, 1'b0, 4'd5, 5'd0, 1'b0, 4'd5, 4'd3, 1'b1, 5'd0);
        cyc(); drive(5'd0, 1'b1, 4'd0, 5'd0, 1'b1, 4'd0, 4'd0, 1'b0, 5'd0);
        #2; all_zero("r0_reader");
        cyc(); nop();
        #2; all_zero("r0_reader_in_e");

        // use=0 with Tuse=5 never stalls even on a pending lw
        cyc(); drive(5'd0, 1'b0, 4'd5, 5'd0, 1'b0, 4'd5, 4'd3, 1'b1, 5'd7);
        cyc(); drive(5'd7, 1'b0, 4'd5, 5'd7, 1'b0, 4'd5, 4'd0, 1'b0, 5'd0);
        #2; check("unused_no_stall", {31'd0, Stall}, 32'd0);

        // three writers of $3 in E, M, W: youngest wins
        for (int i = 0; i < 3; i++) begin
            cyc(); drive(5'd0, 1'b0, 4'd5, 5'd0, 1'b0, 4'd5, 4'd1, 1'b1, 5'd3);
        end
        cyc(); drive(5'd3, 1'b1, 4'd0, 5'd0, 1'b0, 4'd5, 4'd0, 1'b0, 5'd0);
        #2; check("youngest_d", {30'd0, Fwd_D_rs}, 32'd1);
        cyc(); nop();
        #2; check("youngest_e", {30'd0, Fwd_E_rs}, 32'd2);

        // reset asserted mid-stall
        cyc(); drive(5'd29, 1'b1, 4'd1, 5'd0, 1'b0, 4'd5, 4'd3, 1'b1, 5'd8);
        cyc(); drive(5'd8, 1'b1, 4'd1, 5'd0, 1'b0, 4'd5, 4'd2, 1'b1, 5'd10);
        #2; check("pre_reset_stall", {31'd0, Stall}, 32'd1);
        reset = 1'b0;
        #1; all_zero("async_reset");
`ifdef HAZARD_PERF_EN
        check("async_reset_cnt", Stall_Cnt, 32'd0);
`endif
        cyc();
        reset = 1'b1;

        // lw then beq: two stalls; lw then add: one stall
        drive(5'd29, 1'b1, 4'd1, 5'd0, 1'b0, 4'd5, 4'd3, 1'b1, 5'd8);
        cyc(); drive(5'd8, 1'b1, 4'd0, 5'd0, 1'b0, 4'd5, 4'd0, 1'b0, 5'd0);
        #2; check("lw_beq_stall1", {31'd0, Stall}, 32'd1);
        cyc();
        #2; check("lw_beq_stall2", {31'd0, Stall}, 32'd1);
        cyc();
        #2; check("lw_beq_done", {31'd0, Stall}, 32'd0);
        cyc(); drive(5'd29, 1'b1, 4'd1, 5'd0, 1'b0, 4'd5, 4'd3, 1'b1, 5'd8);
        cyc(); drive(5'd8, 1'b1, 4'd1, 5'd0, 1'b0, 4'd5, 4'd2, 1'b1, 5'd11);
        #2; check("lw_add2_stall", {31'd0, Stall}, 32'd1);
        cyc(); nop();
        cyc();
`ifdef HAZARD_PERF_EN
        #2; check("stall_cnt_3", Stall_Cnt, 32'd3);
`endif
        cyc();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
